// File: rtl/bcd_counter2.sv
// Two-digit packed-BCD up/down counter with a synchronised, edge-detected step input,
// validated parallel load and a configurable wrap limit.
module bcd_counter2 #(
  parameter logic [7:0] LIMIT = 8'h99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       carry,
  output logic       borrow,
  output logic       load_err
);

  logic       s1_q, s2_q, s3_q;
  logic [7:0] count_q, count_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       err_q, err_d;
  logic       tick;
  logic       load_ok;

  assign tick    = s2_q & ~s3_q;
  assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) && (load_val <= LIMIT);

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         err_d   = 1'b1;
    end else if (tick && en) begin
      if (up) begin
        if (count_q == LIMIT) begin
          count_d = '0;
          carry_d = 1'b1;
        end else if (count_q[3:0] == 4'd9) begin
          count_d[3:0] = '0;
          count_d[7:4] = count_q[7:4] + 4'd1;
        end else begin
          count_d[3:0] = count_q[3:0] + 4'd1;
        end
      end else begin
        if (count_q == 8'h00) begin
          count_d  = LIMIT;
          borrow_d = 1'b1;
        end else if (count_q[3:0] == 4'd0) begin
          count_d[3:0] = 4'd9;
          count_d[7:4] = count_q[7:4] - 4'd1;
        end else begin
          count_d[3:0] = count_q[3:0] - 4'd1;
        end
      end
    end
  end

  // Synchroniser resets to all ones so a step held high through reset is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      s3_q     <= 1'b1;
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_q     <= step;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign count    = count_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_bcd_counter2.sv
// Directed bench for bcd_counter2: default-limit instance plus a LIMIT=8'h59 instance,
// with a queue of expected outputs checked when the DUT result is due.
module tb_bcd_counter2;

  logic       clk = 1'b0;
  logic       rst, step, en, up, load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       carry, borrow, load_err;
  logic       step2, en2, up2, load2;
  logic [7:0] load_val2;
  logic [7:0] count2;
  logic       carry2, borrow2, load_err2;

  int total = 0;
  int bad   = 0;

  string      tq[$];
  bit         sq[$];
  logic [10:0] eq[$];

  always #5 clk = ~clk;

  bcd_counter2 dut (
    .clk(clk), .rst(rst), .step(step), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .carry(carry), .borrow(borrow), .load_err(load_err)
  );

  bcd_counter2 #(.LIMIT(8'h59)) dut59 (
    .clk(clk), .rst(rst), .step(step2), .en(en2), .up(up2), .load(load2), .load_val(load_val2),
    .count(count2), .carry(carry2), .borrow(borrow2), .load_err(load_err2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit sel, input string tag, input logic [7:0] c,
                      input logic ca, input logic bo, input logic le);
    tq.push_back(tag);
    sq.push_back(sel);
    eq.push_back({c, ca, bo, le});
  endtask

  task automatic check();
    string       tag;
    bit          sel;
    logic [10:0] exp, act;
    tag = tq.pop_front();
    sel = sq.pop_front();
    exp = eq.pop_front();
    act = sel ? {count2, carry2, borrow2, load_err2} : {count, carry, borrow, load_err};
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got count=%h c/b/e=%b required count=%h c/b/e=%b",
             tag, act[10:3], act[2:0], exp[10:3], exp[2:0]);
    end
  endtask

  task automatic pulse(input bit sel, input logic dir, input logic [7:0] c,
                       input logic ca, input logic bo);
    if (sel) begin up2 = dir; step2 = 1'b1; end
    else     begin up  = dir; step  = 1'b1; end
    push(sel, "step", c, ca, bo, 1'b0);
    cyc(); cyc(); cyc();
    check();
    step  = 1'b0;
    step2 = 1'b0;
    cyc(); cyc(); cyc();
    push(sel, "settle", c, 1'b0, 1'b0, 1'b0);
    check();
  endtask

  task automatic do_load(input bit sel, input logic [7:0] v, input logic [7:0] c, input logic le);
    if (sel) begin load2 = 1'b1; load_val2 = v; end
    else     begin load  = 1'b1; load_val  = v; end
    push(sel, "load", c, 1'b0, 1'b0, le);
    cyc();
    check();
  endtask

  logic [7:0] up_seq [12];

  initial begin
    up_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};
    rst = 1'b1; step = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
    step2 = 1'b0; en2 = 1'b1; up2 = 1'b1; load2 = 1'b0; load_val2 = '0;

    // reset with step held high
    cyc(); cyc();
    push(0, "reset", 8'h00, 1'b0, 1'b0, 1'b0); check();
    push(1, "reset59", 8'h00, 1'b0, 1'b0, 1'b0); check();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      push(0, "held_step", 8'h00, 1'b0, 1'b0, 1'b0); check();
    end
    step = 1'b0;
    cyc(); cyc(); cyc();

    // latency of first step: no change after two edges, update on the third
    step = 1'b1;
    push(0, "lat_pre", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(); cyc();
    check();
    push(0, "lat_upd", 8'h01, 1'b0, 1'b0, 1'b0);
    cyc();
    check();
    step = 1'b0;
    cyc(); cyc(); cyc();
    for (int i = 1; i < 12; i++) pulse(0, 1'b1, up_seq[i], 1'b0, 1'b0);

    // load 98, then wrap up with carry
    do_load(0, 8'h98, 8'h98, 1'b0);
    load = 1'b0;
    pulse(0, 1'b1, 8'h99, 1'b0, 1'b0);
    pulse(0, 1'b1, 8'h00, 1'b1, 1'b0);

    // down-wrap with borrow
    pulse(0, 1'b0, 8'h99, 1'b0, 1'b1);
    pulse(0, 1'b0, 8'h98, 1'b0, 1'b0);
    do_load(0, 8'h30, 8'h30, 1'b0);
    load = 1'b0;
    pulse(0, 1'b0, 8'h29, 1'b0, 1'b0);

    // invalid loads, held request pulses every cycle
    do_load(0, 8'h3A, 8'h29, 1'b1);
    do_load(0, 8'hA0, 8'h29, 1'b1);
    do_load(0, 8'hA0, 8'h29, 1'b1);
    load = 1'b0;
    cyc();
    push(0, "err_clear", 8'h29, 1'b0, 1'b0, 1'b0); check();

    // tick coincident with load is dropped
    up = 1'b1;
    step = 1'b1;
    cyc(); cyc();
    do_load(0, 8'h42, 8'h42, 1'b0);
    load = 1'b0;
    cyc();
    push(0, "no_defer", 8'h42, 1'b0, 1'b0, 1'b0); check();
    step = 1'b0;
    cyc(); cyc(); cyc();

    // step with en=0 ignored
    en = 1'b0;
    pulse(0, 1'b1, 8'h42, 1'b0, 1'b0);
    en = 1'b1;
    pulse(0, 1'b1, 8'h43, 1'b0, 1'b0);

    // reset mid-operation overrides pending tick
    step = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    push(0, "mid_reset", 8'h00, 1'b0, 1'b0, 1'b0); check();
    rst = 1'b0;
    step = 1'b0;
    cyc(); cyc(); cyc();
    push(0, "post_reset", 8'h00, 1'b0, 1'b0, 1'b0); check();

    // LIMIT=59 instance
    do_load(1, 8'h60, 8'h00, 1'b1);
    do_load(1, 8'h58, 8'h58, 1'b0);
    load2 = 1'b0;
    pulse(1, 1'b1, 8'h59, 1'b0, 1'b0);
    pulse(1, 1'b1, 8'h00, 1'b1, 1'b0);
    pulse(1, 1'b0, 8'h59, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_counter2.md
Name: bcd_counter2

Overview:
- Two-digit packed-BCD up/down counter driven by a raw step input (button or switch level).
- Produces the 8-bit packed BCD word that the downstream BCD-to-binary converter consumes: tens digit in [7:4], ones digit in [3:0].
- Synchronises and edge-detects the step input internally.
- Supports parallel load of a BCD value with digit validation, and a configurable wrap limit.

Parameters:
- LIMIT, 8'h99: packed-BCD upper count limit; both digits must be 0-9. Counting wraps LIMIT->00 going up and 00->LIMIT going down.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- step  input  1  raw asynchronous step level; each low->high transition requests one count.
- en  input  1  count enable; gates step ticks only, not load.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled when the tick is applied.
- load  input  1  parallel load request, level-sampled each cycle.
- load_val  input  8  packed-BCD value to load.
- count  output  8  current packed-BCD count; registered.
- carry  output  1  one-cycle pulse on an up-wrap LIMIT->00.
- borrow  output  1  one-cycle pulse on a down-wrap 00->LIMIT.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst=1 at a rising edge):
  - count=8'h00, carry=0, borrow=0, load_err=0.
  - The step synchroniser chain (s1, s2, s3) is set to all 1s, so a step held high through reset does not count. A low then high is required after reset.
- Synchroniser: s1<=step, s2<=s1, s3<=s2 each cycle. tick = s2 & ~s3 is high for exactly one cycle per rising edge of step.
- Latency: step first sampled high at edge t -> tick high in the cycle after edge t+1 -> count updates at edge t+2.
- Priority per edge: rst > load > (tick & en). A tick that coincides with a load, or arrives with en=0, is dropped, not deferred.
- Load:
  - load_val is valid if both digits are <=9 and load_val <= LIMIT, compared as BCD (numerically equal to an unsigned compare for valid BCD).
  - Valid: count<=load_val, load_err=0.
  - Invalid: count unchanged, load_err pulses 1 for one cycle.
  - Load never asserts carry or borrow.
  - load held high for N cycles reloads every cycle; an invalid value held high pulses load_err every cycle.
- Increment (tick & en & up):
  - count==LIMIT -> count<=8'h00, carry=1.
  - ones==9 -> ones<=0, tens<=tens+1.
  - otherwise ones<=ones+1.
- Decrement (tick & en & ~up):
  - count==8'h00 -> count<=LIMIT, borrow=1.
  - ones==0 -> ones<=9, tens<=tens-1.
  - otherwise ones<=ones-1.
- carry and borrow are registered and assert on the same edge that updates count. They are 0 on every other cycle; they never assert together.
- Invariant: count is always valid BCD and <= LIMIT; no binary intermediate ever appears on count.
- Reset mid-operation: takes effect at that edge, overrides any pending tick or load, and clears all pulse outputs.
- No other outputs change on non-tick, non-load cycles.

Test Plan:
- rst=1 for 2 cycles with step=1 held, then rst=0 with step kept high for 10 cycles -> count=8'h00, no tick, carry/borrow/load_err=0.
- en=1, up=1, 12 clean step pulses from count 00 -> count 8'h12; the update lands 3 edges after each step rise; ones wraps 09->10 correctly.
- load load_val=8'h98, then 2 up-steps -> 8'h99 then 8'h00, with carry=1 for exactly the cycle of the 99->00 update.
- From 8'h00, up=0, 1 step -> count 8'h99, borrow=1 for one cycle; next step -> 8'h98, borrow=0.
- load_val=8'h3A with load=1, then 8'hA0 -> count unchanged, load_err pulses each time. With LIMIT=8'h59, load_val=8'h60 -> rejected, and up-wrap goes 59->00.
- Step tick coincident with load=1 (load_val=8'h42) -> count=8'h42, no extra increment. Step pulse with en=0 -> count unchanged.
